// File: rtl/reservation_station.sv
// reservation_station
// ALU reservation station for the out-of-order MIPS core. Dispatched
// operations wait here until both source operands hold values. Missing
// operands are captured by snooping the common data bus. The oldest ready
// entry is presented to the ALU.
//
// Storage is a compacting queue. Entry 0 is always the oldest, and valid
// entries occupy indices 0..count-1 with no gaps.
//
// Ports
//   clk_i, rst_i             clock; synchronous active-high reset
//   flush_i                  squash every entry (mispredict recovery)
//   disp_*_i / disp_ready_o  dispatch request, operation fields, space available
//   cdb_valid_i/tag_i/data_i common data bus broadcast
//   issue_valid_o / issue_ready_i  issue handshake with the ALU
//   issue_tag_o/op_o/op1_o/op2_o   selected operation (zero when none)
module reservation_station #(
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = 6,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  disp_valid_i,
   output logic                  disp_ready_o,
   input  logic [TAG_WIDTH-1:0]  disp_tag_i,
   input  logic [OP_WIDTH-1:0]   disp_op_i,
   input  logic                  disp_src1_ready_i,
   input  logic                  disp_src2_ready_i,
   input  logic [TAG_WIDTH-1:0]  disp_src1_tag_i,
   input  logic [TAG_WIDTH-1:0]  disp_src2_tag_i,
   input  logic [DATA_WIDTH-1:0] disp_src1_data_i,
   input  logic [DATA_WIDTH-1:0] disp_src2_data_i,
   input  logic                  cdb_valid_i,
   input  logic [TAG_WIDTH-1:0]  cdb_tag_i,
   input  logic [DATA_WIDTH-1:0] cdb_data_i,
   output logic                  issue_valid_o,
   input  logic                  issue_ready_i,
   output logic [TAG_WIDTH-1:0]  issue_tag_o,
   output logic [OP_WIDTH-1:0]   issue_op_o,
   output logic [DATA_WIDTH-1:0] issue_op1_o,
   output logic [DATA_WIDTH-1:0] issue_op2_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef struct packed {
      logic                  valid;
      logic [TAG_WIDTH-1:0]  tag;
      logic [OP_WIDTH-1:0]   op;
      logic                  rdy1;
      logic [TAG_WIDTH-1:0]  stag1;
      logic [DATA_WIDTH-1:0] data1;
      logic                  rdy2;
      logic [TAG_WIDTH-1:0]  stag2;
      logic [DATA_WIDTH-1:0] data2;
   } entry_t;

   entry_t        ent_q [DEPTH];
   entry_t        ent_d [DEPTH];
   // Post-snoop view of every entry. The extra top slot is an empty entry
   // that shifts into the highest index when an issue compacts the queue.
   entry_t        sn_ent [DEPTH+1];
   entry_t        disp_ent;

   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] wr_idx;
   logic          sel_found;
   logic [IW-1:0] sel_idx;
   logic          issue_fire;
   logic          disp_fire;

   // CDB snoop on the stored entries
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         sn_ent[i] = ent_q[i];
         if (cdb_valid_i && ent_q[i].valid && !ent_q[i].rdy1 &&
             ent_q[i].stag1 == cdb_tag_i) begin
            sn_ent[i].rdy1  = 1'b1;
            sn_ent[i].data1 = cdb_data_i;
         end
         if (cdb_valid_i && ent_q[i].valid && !ent_q[i].rdy2 &&
             ent_q[i].stag2 == cdb_tag_i) begin
            sn_ent[i].rdy2  = 1'b1;
            sn_ent[i].data2 = cdb_data_i;
         end
      end
      sn_ent[DEPTH] = '0;
   end

   // Oldest ready entry. Only registered readiness is used, so a value
   // captured from the CDB this cycle becomes issuable next cycle.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   assign issue_valid_o = sel_found & ~flush_i;
   assign issue_tag_o   = sel_found ? ent_q[sel_idx].tag   : '0;
   assign issue_op_o    = sel_found ? ent_q[sel_idx].op    : '0;
   assign issue_op1_o   = sel_found ? ent_q[sel_idx].data1 : '0;
   assign issue_op2_o   = sel_found ? ent_q[sel_idx].data2 : '0;

   assign disp_ready_o  = (count_q != CW'(DEPTH));
   assign issue_fire    = issue_valid_o & issue_ready_i;
   assign disp_fire     = disp_valid_i & disp_ready_o;

   // A same-cycle issue frees one slot below the current tail
   assign wr_idx  = issue_fire ? (count_q - CW'(1)) : count_q;
   assign count_d = count_q + CW'(disp_fire) - CW'(issue_fire);

   // New entry, with operands bypassed from a coincident CDB broadcast
   always_comb begin
      disp_ent       = '0;
      disp_ent.valid = 1'b1;
      disp_ent.tag   = disp_tag_i;
      disp_ent.op    = disp_op_i;
      disp_ent.stag1 = disp_src1_tag_i;
      disp_ent.stag2 = disp_src2_tag_i;
      if (disp_src1_ready_i) begin
         disp_ent.rdy1  = 1'b1;
         disp_ent.data1 = disp_src1_data_i;
      end else if (cdb_valid_i && disp_src1_tag_i == cdb_tag_i) begin
         disp_ent.rdy1  = 1'b1;
         disp_ent.data1 = cdb_data_i;
      end
      if (disp_src2_ready_i) begin
         disp_ent.rdy2  = 1'b1;
         disp_ent.data2 = disp_src2_data_i;
      end else if (cdb_valid_i && disp_src2_tag_i == cdb_tag_i) begin
         disp_ent.rdy2  = 1'b1;
         disp_ent.data2 = cdb_data_i;
      end
   end

   // Compaction: entries at or above the issued slot move down one index
   // and keep whatever they captured from the CDB this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && i >= int'(sel_idx)) begin
            ent_d[i] = sn_ent[i+1];
         end else begin
            ent_d[i] = sn_ent[i];
         end
         if (disp_fire && int'(wr_idx) == i) begin
            ent_d[i] = disp_ent;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i].valid <= 1'b0;
         end
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         count_q <= count_d;
      end
   end

endmodule
